// File: rtl/counter_seq_checker.sv
// rtl/counter_seq_checker.sv - receive-side checker for a wrapping 0..NUM_MAX count stream
// Seeds on a valid sample, locks after LOCK_COUNT in-sequence samples, then flags breaks and wraps.
module counter_seq_checker #(
  parameter int NUM_MAX       = 16,
  parameter bit UP_DOWN       = 1'b1,
  parameter int DATA_WIDTH    = $clog2(NUM_MAX + 1),
  parameter int LOCK_COUNT    = 2,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_clr,
  input  logic                     i_valid,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic                     o_locked,
  output logic [DATA_WIDTH-1:0]    o_expected,
  output logic                     o_err,
  output logic                     o_range_err,
  output logic                     o_wrap,
  output logic [ERR_CNT_WIDTH-1:0] o_err_count
);

  localparam int MCW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [DATA_WIDTH-1:0] MAX_V  = DATA_WIDTH'(NUM_MAX);
  localparam logic [MCW-1:0]        LOCK_V = MCW'(LOCK_COUNT);
  localparam logic [MCW-1:0]        ONE_V  = MCW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // A fresh seed already counts as one match, so LOCK_COUNT==1 locks straight from the seed.
  localparam state_t RESEED_ST = (LOCK_COUNT == 1) ? ST_LOCKED : ST_ACQUIRE;

  state_t                   state_q;
  logic [MCW-1:0]           match_cnt_q;
  logic [DATA_WIDTH-1:0]    expected_q;
  logic                     err_q;
  logic                     range_err_q;
  logic                     wrap_q;
  logic [ERR_CNT_WIDTH-1:0] err_count_q;

  logic                  in_range;
  logic                  hit;
  logic                  wrap_pt;
  logic                  err_d;
  logic [DATA_WIDTH-1:0] seed_d;
  logic [MCW-1:0]        match_inc_d;

  function automatic logic [DATA_WIDTH-1:0] next_val(input logic [DATA_WIDTH-1:0] x);
    if (UP_DOWN) next_val = (x == MAX_V) ? '0 : x + 1'b1;
    else         next_val = (x == '0) ? MAX_V : x - 1'b1;
  endfunction

  assign in_range    = (i_data <= MAX_V);
  assign hit         = (i_data == expected_q);
  assign seed_d      = next_val(i_data);
  assign wrap_pt     = UP_DOWN ? (i_data == '0) : (i_data == MAX_V);
  assign err_d       = i_valid && (state_q == ST_LOCKED) && (!in_range || !hit);
  assign match_inc_d = match_cnt_q + ONE_V;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      match_cnt_q <= '0;
      expected_q  <= '0;
      err_q       <= 1'b0;
      range_err_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      err_q       <= err_d;
      range_err_q <= i_valid && !in_range;
      wrap_q      <= 1'b0;
      if (i_valid) begin
        unique case (state_q)
          ST_IDLE: begin
            if (in_range) begin
              expected_q  <= seed_d;
              match_cnt_q <= ONE_V;
              state_q     <= RESEED_ST;
            end
          end
          ST_ACQUIRE: begin
            if (!in_range) begin
              match_cnt_q <= '0;
              state_q     <= ST_IDLE;
            end else if (hit) begin
              expected_q  <= seed_d;
              match_cnt_q <= match_inc_d;
              if (match_inc_d >= LOCK_V) state_q <= ST_LOCKED;
            end else begin
              expected_q  <= seed_d;
              match_cnt_q <= ONE_V;
            end
          end
          ST_LOCKED: begin
            if (!in_range) begin
              match_cnt_q <= '0;
              state_q     <= ST_IDLE;
            end else if (hit) begin
              expected_q <= seed_d;
              wrap_q     <= wrap_pt;
            end else begin
              expected_q  <= seed_d;
              match_cnt_q <= ONE_V;
              state_q     <= RESEED_ST;
            end
          end
          default: begin
            match_cnt_q <= '0;
            state_q     <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Clear takes priority over a same-cycle error so software sees a clean zero.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_count_q <= '0;
    end else if (i_clr) begin
      err_count_q <= '0;
    end else if (err_d && (err_count_q != '1)) begin
      err_count_q <= err_count_q + 1'b1;
    end
  end

  assign o_locked    = (state_q == ST_LOCKED);
  assign o_expected  = expected_q;
  assign o_err       = err_q;
  assign o_range_err = range_err_q;
  assign o_wrap      = wrap_q;
  assign o_err_count = err_count_q;

  if (NUM_MAX < 1) begin : g_bad_num_max
    $error("counter_seq_checker: NUM_MAX must be >= 1");
  end
  if (LOCK_COUNT < 1) begin : g_bad_lock_count
    $error("counter_seq_checker: LOCK_COUNT must be >= 1");
  end

endmodule
